// File: rtl/irq_pend_latch_pkg.sv
// irq_pkg: shared widths and types for the interrupt pending latch.
package irq_pkg;
    localparam int N_REQ = 4;
    typedef logic [N_REQ-1:0] req_vec_t;
    typedef logic [$clog2(N_REQ)-1:0] req_id_t;
endpackage

// File: rtl/irq_pend_latch_sync.sv
// req_sync: single-bit synchronizer chain for one asynchronous request line.
module req_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [SYNC_STAGES-1:0] q_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= {q_q[SYNC_STAGES-2:0], d};
    end
    assign q = q_q[SYNC_STAGES-1];
endmodule

// File: rtl/irq_pend_latch.sv
// irq_pend_latch: sticky per-line pending bits with ack clear and mask gate.
// Define IRQ_OVF_EN to add the sticky overflow flags and the ovf port.
module irq_pend_latch
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             ack,
    input  logic [1:0]       ack_id,
    output logic [N_REQ-1:0] pend,
    output logic [N_REQ-1:0] pend_raw
`ifdef IRQ_OVF_EN
    ,
    output logic [N_REQ-1:0] ovf
`endif
);
    req_vec_t s, h_q, e, clr, pend_raw_q, pend_raw_d;
    for (genvar i = 0; i < N_REQ; i++) begin : g_sync
        req_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .d    (req_in[i]),
            .q    (s[i])
        );
    end
    assign e          = s & ~h_q;
    assign clr        = ack ? req_vec_t'(1) << ack_id : '0;
    // Set wins over clear so an event landing in the ack cycle is kept.
    assign pend_raw_d = e | (pend_raw_q & ~clr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q        <= '0;
            pend_raw_q <= '0;
        end else begin
            h_q        <= s;
            pend_raw_q <= pend_raw_d;
        end
    end
    assign pend_raw = pend_raw_q;
    assign pend     = pend_raw_q & ~mask;
`ifdef IRQ_OVF_EN
    req_vec_t ovf_q, ovf_d;
    assign ovf_d = (e & pend_raw_q & ~clr) | (ovf_q & ~clr);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end
    assign ovf = ovf_q;
`endif
endmodule

// File: tb/tb_irq_pend_latch.sv
// tb_irq_pend_latch: directed self-checking bench for irq_pend_latch.
module tb_irq_pend_latch;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req_in, mask, pend, pend_raw;
    logic       ack;
    logic [1:0] ack_id;
`ifdef IRQ_OVF_EN
    logic [3:0] ovf;
`endif
    int errs = 0;
    int checks = 0;

    irq_pend_latch dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_in  (req_in),
        .mask    (mask),
        .ack     (ack),
        .ack_id  (ack_id),
        .pend    (pend),
        .pend_raw(pend_raw)
`ifdef IRQ_OVF_EN
        ,
        .ovf     (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle pulse; pend_raw reflects it after the third edge.
    task automatic pulse(input logic [3:0] v);
        req_in = v;
        tick();
        req_in = '0;
        tick();
        tick();
    endtask

    task automatic do_ack(input logic [1:0] id);
        ack = 1'b1;
        ack_id = id;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; req_in = 4'b1111; mask = '0; ack = 1'b0; ack_id = '0;
        tick(); tick();
        chk("rst_pend", pend, 4'b0000);
        chk("rst_pend_raw", pend_raw, 4'b0000);
`ifdef IRQ_OVF_EN
        chk("rst_ovf", ovf, 4'b0000);
`endif
        rst_n = 1'b1;
        tick(); tick();
        chk("held_edge2", pend_raw, 4'b0000);
        tick();
        chk("held_edge3", pend_raw, 4'b1111);
        req_in = '0;
        for (int i = 0; i < 4; i++) do_ack(2'(i));
        chk("ack_all", pend_raw, 4'b0000);

        pulse(4'b0100);
        chk("pulse2", pend, 4'b0100);
        do_ack(2'd2);
        chk("ack2", pend, 4'b0000);

        mask = 4'b0001;
        pulse(4'b0001);
        chk("mask_raw", pend_raw, 4'b0001);
        chk("mask_pend", pend, 4'b0000);
        mask = 4'b0000;
        #1;
        chk("unmask_comb", pend, 4'b0001);
        mask = 4'b0001;
        do_ack(2'd0);
        chk("ack_masked", pend_raw, 4'b0000);
        mask = 4'b0000;

        pulse(4'b0010);
        chk("line1_set", pend_raw, 4'b0010);
        req_in = 4'b0010;
        tick();
        req_in = '0;
        tick();
        do_ack(2'd1);
        chk("set_beats_clr", pend_raw, 4'b0010);
`ifdef IRQ_OVF_EN
        chk("set_clr_ovf", ovf, 4'b0000);
`endif
        do_ack(2'd3);
        chk("ack_idle_line", pend_raw, 4'b0010);
        do_ack(2'd1);
        chk("ack1", pend_raw, 4'b0000);

        pulse(4'b1000);
        pulse(4'b1000);
        chk("ovf_raw", pend_raw, 4'b1000);
`ifdef IRQ_OVF_EN
        chk("ovf_set", ovf, 4'b1000);
`endif
        do_ack(2'd3);
        chk("ovf_ack_raw", pend_raw, 4'b0000);
`ifdef IRQ_OVF_EN
        chk("ovf_ack", ovf, 4'b0000);
`endif

        pulse(4'b1010);
        chk("multi_set", pend_raw, 4'b1010);
        mask = 4'b0010;
        #1;
        chk("multi_mask", pend, 4'b1000);
        mask = 4'b0000;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_raw", pend_raw, 4'b0000);
        chk("async_pend", pend, 4'b0000);
`ifdef IRQ_OVF_EN
        chk("async_ovf", ovf, 4'b0000);
`endif
        tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        chk("post_rst_idle", pend_raw, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
